adapt_uart_tx_fifo: RTL and testbench
=====================================

// Module: adapt_uart_tx_fifo
// PURPOSE
//  Parametrised successor to the single-byte adaptive serializer: buffered UART transmitter.
//  - Words enter a FIFO via a valid/ready handshake.
//  - Each word is serialised as start, DATA_W data bits LSB first, optional parity, then stop.
//  - Flags a frame whose data repeats the previous frame's data when idle_mode is set.
//  - Sits behind the tt_um top-level pin mapping; the top drives wr_* from ui_in/uio_in.
// PARAMETERS
//  DATA_W        8   payload bits per frame (4..16)
//  FIFO_DEPTH    4   FIFO entries; power of two, >=2
//  CLKS_PER_BIT  16  clk cycles per serial bit (>=2)
//  PARITY_EN     1   1: insert parity bit after data; 0: no parity bit
// PORTS
//  clk         in   1                       system clock, rising edge
//  rst_n       in   1                       asynchronous active-low reset
//  wr_data     in   DATA_W                  word to enqueue
//  wr_valid    in   1                       wr_data valid
//  wr_ready    out  1                       FIFO can accept (= !full)
//  parity_odd  in   1                       1 odd / 0 even parity; sampled at frame start
//  idle_mode   in   1                       enables repeat detection; sampled at frame start
//  tx          out  1                       serial line, idles high
//  busy        out  1                       frame in progress (state != IDLE)
//  rep_flag    out  1                       current frame repeats previous data
//  fifo_level  out  $clog2(FIFO_DEPTH+1)    entries held
//  overrun     out  1                       sticky: write attempted while full
// BEHAVIOUR
//  Reset values (async, immediate, also mid-frame):
//  - tx=1, busy=0, rep_flag=0, fifo_level=0, overrun=0, wr_ready=1.
//  - FIFO pointers cleared; last-data register cleared; "first frame" marker set.
//  - A frame cut short by reset is discarded, not resumed.
//  Write side:
//  - Push when wr_valid&&wr_ready on a rising edge.
//  - wr_valid while full: word dropped, overrun set until reset.
//  Frame FSM: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE/START.
//  - IDLE, FIFO non-empty: pop head, latch shift reg, parity_odd, idle_mode; go to START.
//  - Pop and tx=0 take effect on the same edge.
//  - Latency: word pushed into empty FIFO at edge k -> tx low from edge k+1.
//  - Each state holds for exactly CLKS_PER_BIT cycles (bit counter 0..CLKS_PER_BIT-1).
//  - DATA: DATA_W bit periods, LSB first; data bit index counter wraps to 0 on exit.
//  - Parity bit = XOR(data) ^ parity_odd.
//  - STOP: tx=1. On the last cycle, if FIFO non-empty, pop and go straight to START
//    (back-to-back frames, no idle gap); else go to IDLE.
//  Frame length: (2+DATA_W+PARITY_EN)*CLKS_PER_BIT cycles (176 at defaults).
//  Simultaneous push and pop: both occur; fifo_level unchanged; pointers wrap modulo FIFO_DEPTH.
//  - Full at that edge: push still blocked, because wr_ready is registered-state based.
//  rep_flag, evaluated at pop:
//  - Set = latched idle_mode && !first_frame && data==last_data.
//  - Held for the whole frame; cleared when returning to IDLE.
//  - last_data updated at every pop; first_frame cleared at the first pop.
//  parity_odd and idle_mode changes mid-frame do not affect the current frame.
// STRUCTURE
//  - Shared package: FSM state enum (IDLE, START, DATA, PARITY, STOP) and default
//    parameter constants.
//  - One sub-module: sync_fifo (params DATA_W, DEPTH) providing push/pop/full/empty/level.
//  - The FSM, baud counter, shift register and repeat compare live in this module.
// TESTING (defaults unless noted)
//  - Reset: hold rst_n=0 20ns -> tx=1, busy=0, wr_ready=1, fifo_level=0.
//    Pull rst_n low mid-DATA -> tx=1 in the same cycle.
//  - Push 0xA5, idle_mode=0, parity_odd=0 -> tx low 1 clk after push, then bits
//    1,0,1,0,0,1,0,1, parity 0, stop 1, each 16 clks; busy low after 176 clks.
//  - Push 0xA5 twice, idle_mode=1 -> second frame back-to-back with no idle cycle,
//    rep_flag=1 for that frame only.
//    Then 0x3C -> rep_flag=0; parity bit 0 even, 1 when parity_odd=1.
//  - Hold wr_valid 6 cycles while idle -> 1 word popped immediately, 4 buffered,
//    wr_ready=0, 6th write dropped, overrun=1 sticky.
//    All 5 frames emitted in order, fifo_level counts back to 0.
//  - DATA_W=5, PARITY_EN=0, CLKS_PER_BIT=4: push 5'h13 -> frame 0,1,1,0,0,1,1 (start,
//    data LSB first, stop), 28 clks total.

Source files
------------

// File: rtl/adapt_uart_tx_fifo_pkg.sv
// Shared types and default parameter values for the buffered UART transmitter.
package adapt_uart_tx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_PARITY_EN    = 1;

endpackage

// File: rtl/adapt_uart_tx_fifo_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO; DEPTH must be a power of two
// so the pointers wrap naturally.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DATA_W-1:0]            wdata_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!do_push && do_pop) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage carries no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/adapt_uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed serializer with optional parity and
// repeated-data flagging.
module adapt_uart_tx_fifo
  import adapt_uart_tx_fifo_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY_EN    = DEF_PARITY_EN
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_W-1:0]                 wr_data,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic                              parity_odd,
  input  logic                              idle_mode,
  output logic                              tx,
  output logic                              busy,
  output logic                              rep_flag,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overrun
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIDX_W = $clog2(DATA_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_W - 1);

  state_e            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [BIDX_W-1:0] bidx_q;
  logic [DATA_W-1:0] shift_q, last_q, head;
  logic              parity_q, first_q, tx_q, busy_q, rep_q;
  logic              overrun_q, overrun_d;
  logic              fifo_full, fifo_empty, push, pop, bit_done;

  assign wr_ready  = !fifo_full;
  assign push      = wr_valid && !fifo_full;
  assign bit_done  = (baud_q == BAUD_LAST);
  // A new frame starts from idle, or straight out of the last stop cycle.
  assign pop       = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_done));
  assign overrun_d = overrun_q || (wr_valid && fifo_full);

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign rep_flag = rep_q;
  assign overrun  = overrun_q;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_data),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bidx_q   <= '0;
      shift_q  <= '0;
      last_q   <= '0;
      parity_q <= 1'b0;
      first_q  <= 1'b1;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      rep_q    <= 1'b0;
    end else begin
      if (pop || (state_q == ST_IDLE) || bit_done) begin
        baud_q <= '0;
      end else begin
        baud_q <= baud_q + BAUD_W'(1);
      end

      // Parity and repeat status are fixed here so mid-frame input changes are ignored.
      if (pop) begin
        state_q  <= ST_START;
        shift_q  <= head;
        parity_q <= (^head) ^ parity_odd;
        rep_q    <= idle_mode && !first_q && (head == last_q);
        last_q   <= head;
        first_q  <= 1'b0;
        tx_q     <= 1'b0;
        busy_q   <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
          end
          ST_START: begin
            if (bit_done) begin
              state_q <= ST_DATA;
              tx_q    <= shift_q[0];
            end
          end
          ST_DATA: begin
            if (bit_done) begin
              if (bidx_q == BIDX_LAST) begin
                bidx_q <= '0;
                if (PARITY_EN != 0) begin
                  state_q <= ST_PARITY;
                  tx_q    <= parity_q;
                end else begin
                  state_q <= ST_STOP;
                  tx_q    <= 1'b1;
                end
              end else begin
                bidx_q  <= bidx_q + BIDX_W'(1);
                shift_q <= shift_q >> 1;
                tx_q    <= shift_q[1];
              end
            end
          end
          ST_PARITY: begin
            if (bit_done) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end
          end
          ST_STOP: begin
            if (bit_done) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              rep_q   <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rep_q   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adapt_uart_tx_fifo.sv
// Self-checking bench for adapt_uart_tx_fifo: frame-level reference model,
// table-driven frames, multi-cycle corner sequences and a small-config instance.
module tb_adapt_uart_tx_fifo;

  localparam int DW         = 8;
  localparam int DEPTH      = 4;
  localparam int CPB        = 16;
  localparam int FRAME_BITS = 11;
  localparam int FRAME_CYC  = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wrData;
  logic       wrValid, parityOdd, idleMode;
  logic       wrReady, tx, busy, repFlag, overrun;
  logic [2:0] fifoLevel;

  logic [4:0] sWrData;
  logic       sWrValid, sWrReady, sTx, sBusy, sRepFlag, sOverrun;
  logic [2:0] sFifoLevel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adapt_uart_tx_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data    (wrData),
    .wr_valid   (wrValid),
    .wr_ready   (wrReady),
    .parity_odd (parityOdd),
    .idle_mode  (idleMode),
    .tx         (tx),
    .busy       (busy),
    .rep_flag   (repFlag),
    .fifo_level (fifoLevel),
    .overrun    (overrun)
  );

  adapt_uart_tx_fifo #(
    .DATA_W       (5),
    .FIFO_DEPTH   (4),
    .CLKS_PER_BIT (4),
    .PARITY_EN    (0)
  ) dutSmall (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data    (sWrData),
    .wr_valid   (sWrValid),
    .wr_ready   (sWrReady),
    .parity_odd (1'b0),
    .idle_mode  (1'b0),
    .tx         (sTx),
    .busy       (sBusy),
    .rep_flag   (sRepFlag),
    .fifo_level (sFifoLevel),
    .overrun    (sOverrun)
  );

  // Frame-level model: queue of buffered words plus the bit list of the frame on the line.
  logic [7:0] mQ[$];
  logic       mBits [FRAME_BITS];
  bit         mActive;
  int         mCyc;
  logic       mRep;
  logic [7:0] mLast;
  bit         mFirst;
  logic       mOverrun;

  function automatic void modelReset();
    mQ.delete();
    mActive  = 0;
    mCyc     = 0;
    mRep     = 1'b0;
    mLast    = '0;
    mFirst   = 1;
    mOverrun = 1'b0;
  endfunction

  function automatic void modelStep(input logic v, input logic [7:0] d,
                                    input logic po, input logic im);
    int         sz;
    bit         popNow;
    logic [7:0] w;
    sz     = mQ.size();
    popNow = (sz > 0) && (!mActive || (mCyc == FRAME_CYC - 1));
    if (mActive) begin
      if (mCyc == FRAME_CYC - 1) begin
        mActive = 0;
        mRep    = 1'b0;
      end else begin
        mCyc++;
      end
    end
    if (popNow) begin
      w = mQ.pop_front();
      mBits[0] = 1'b0;
      for (int i = 0; i < DW; i++) mBits[1+i] = w[i];
      mBits[DW+1] = (^w) ^ po;
      mBits[DW+2] = 1'b1;
      mCyc    = 0;
      mActive = 1;
      mRep    = im && !mFirst && (w == mLast);
      mLast   = w;
      mFirst  = 0;
    end
    if (v) begin
      if (sz < DEPTH) mQ.push_back(d);
      else mOverrun = 1'b1;
    end
  endfunction

  task automatic checkVal(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, actual, expected);
    end
  endtask

  task automatic checkOutput();
    checkVal("tx", 16'(tx), 16'(mActive ? mBits[mCyc / CPB] : 1'b1));
    checkVal("busy", 16'(busy), 16'(mActive));
    checkVal("rep_flag", 16'(repFlag), 16'(mRep));
    checkVal("fifo_level", 16'(fifoLevel), 16'(mQ.size()));
    checkVal("wr_ready", 16'(wrReady), 16'(mQ.size() < DEPTH));
    checkVal("overrun", 16'(overrun), 16'(mOverrun));
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic po, input logic im);
    wrValid   = v;
    wrData    = d;
    parityOdd = po;
    idleMode  = im;
    modelStep(v, d, po, im);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    wrValid  = 1'b0;
    sWrValid = 1'b0;
    rst_n    = 1'b0;
    modelReset();
    #2;
    checkVal("reset_tx", 16'(tx), 16'd1);
    checkVal("reset_busy", 16'(busy), 16'd0);
    checkVal("reset_wr_ready", 16'(wrReady), 16'd1);
    checkVal("reset_fifo_level", 16'(fifoLevel), 16'd0);
    checkVal("reset_overrun", 16'(overrun), 16'd0);
    checkVal("reset_rep_flag", 16'(repFlag), 16'd0);
    #18;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        po;
    logic        im;
    logic [10:0] frame;
    logic        rep;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       po, im;
    logic [6:0] expSmall;

    // Transmit order is bit 0 first: start, data LSB..MSB, parity, stop.
    vecs[0] = '{8'hA5, 1'b0, 1'b0, {1'b1, 1'b0, 8'hA5, 1'b0}, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 1'b1, {1'b1, 1'b0, 8'hA5, 1'b0}, 1'b1};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, {1'b1, 1'b0, 8'h3C, 1'b0}, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, {1'b1, 1'b1, 8'h3C, 1'b0}, 1'b1};
    vecs[4] = '{8'h3C, 1'b1, 1'b0, {1'b1, 1'b1, 8'h3C, 1'b0}, 1'b0};
    vecs[5] = '{8'h01, 1'b0, 1'b0, {1'b1, 1'b1, 8'h01, 1'b0}, 1'b0};
    vecs[6] = '{8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h01, 1'b0}, 1'b1};
    vecs[7] = '{8'hFF, 1'b1, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b0};
    vecs[8] = '{8'h80, 1'b1, 1'b0, {1'b1, 1'b0, 8'h80, 1'b0}, 1'b0};

    wrData = '0; wrValid = 1'b0; parityOdd = 1'b0; idleMode = 1'b0;
    sWrData = '0; sWrValid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    doReset();

    // Table frames; parity_odd/idle_mode are inverted after the pop edge.
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].data, vecs[i].po, vecs[i].im);
      for (int t = 1; t <= FRAME_CYC + 1; t++) begin
        po = (t >= 2) ? ~vecs[i].po : vecs[i].po;
        im = (t >= 2) ? ~vecs[i].im : vecs[i].im;
        applyStimulus(1'b0, vecs[i].data, po, im);
        if (t == 1) checkVal($sformatf("vec%0d_start_latency", i), 16'(tx), 16'd0);
        if (t == 8) checkVal($sformatf("vec%0d_rep", i), 16'(repFlag), 16'(vecs[i].rep));
        if ((t <= FRAME_CYC) && (((t - 1) % CPB) == 8))
          checkVal($sformatf("vec%0d_bit%0d", i, (t - 1) / CPB), 16'(tx),
                   16'(vecs[i].frame[(t - 1) / CPB]));
        if (t == FRAME_CYC) checkVal($sformatf("vec%0d_busy_last", i), 16'(busy), 16'd1);
        if (t == FRAME_CYC + 1) checkVal($sformatf("vec%0d_busy_end", i), 16'(busy), 16'd0);
      end
      repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    end

    // Back-to-back identical words with repeat detection enabled.
    doReset();
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1);
    for (int t = 2; t <= 2 * FRAME_CYC + 1; t++) begin
      applyStimulus(1'b0, 8'hA5, 1'b0, 1'b1);
      if (t == 100) checkVal("b2b_first_rep", 16'(repFlag), 16'd0);
      if (t == FRAME_CYC) checkVal("b2b_stop_tx", 16'(tx), 16'd1);
      if (t == FRAME_CYC + 1) begin
        checkVal("b2b_no_gap_tx", 16'(tx), 16'd0);
        checkVal("b2b_no_gap_busy", 16'(busy), 16'd1);
        checkVal("b2b_second_rep", 16'(repFlag), 16'd1);
      end
      if (t == 2 * FRAME_CYC) checkVal("b2b_rep_held", 16'(repFlag), 16'd1);
      if (t == 2 * FRAME_CYC + 1) begin
        checkVal("b2b_idle_busy", 16'(busy), 16'd0);
        checkVal("b2b_idle_rep", 16'(repFlag), 16'd0);
      end
    end
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1);
    repeat (10) applyStimulus(1'b0, 8'h3C, 1'b0, 1'b1);
    checkVal("new_data_rep", 16'(repFlag), 16'd0);
    repeat (FRAME_CYC) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Six consecutive writes while idle: one popped, four buffered, one dropped.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
    checkVal("burst_level", 16'(fifoLevel), 16'd4);
    checkVal("burst_wr_ready", 16'(wrReady), 16'd0);
    checkVal("burst_overrun", 16'(overrun), 16'd1);
    repeat (5 * FRAME_CYC + 10) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkVal("burst_drained_level", 16'(fifoLevel), 16'd0);
    checkVal("burst_drained_busy", 16'(busy), 16'd0);
    checkVal("burst_overrun_sticky", 16'(overrun), 16'd1);

    // Asynchronous reset in the middle of a data bit.
    doReset();
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    repeat (40) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkVal("mid_data_tx_low", 16'(tx), 16'd0);
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkVal("async_reset_tx", 16'(tx), 16'd1);
    checkVal("async_reset_busy", 16'(busy), 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkVal("frame_discarded", 16'(busy), 16'd0);

    // Randomized traffic against the model.
    doReset();
    po = 1'b0;
    im = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 3))
        0:       d = 8'hA5;
        1:       d = 8'h3C;
        default: d = 8'($urandom);
      endcase
      if ($urandom_range(0, 49) == 0) po = ~po;
      if ($urandom_range(0, 49) == 0) im = ~im;
      applyStimulus(($urandom_range(0, 99) < 4), d, po, im);
    end
    repeat (5 * FRAME_CYC + 10) applyStimulus(1'b0, 8'h00, po, im);
    checkVal("random_drained_level", 16'(fifoLevel), 16'd0);

    // Small configuration: 5 data bits, no parity, 4 clocks per bit.
    doReset();
    expSmall = 7'b1100110;
    sWrData  = 5'h13;
    sWrValid = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    sWrValid = 1'b0;
    for (int t = 1; t <= 29; t++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      if ((t <= 28) && (((t - 1) % 4) == 2))
        checkVal($sformatf("small_bit%0d", (t - 1) / 4), 16'(sTx), 16'(expSmall[(t - 1) / 4]));
      if (t == 28) checkVal("small_busy_last", 16'(sBusy), 16'd1);
      if (t == 29) checkVal("small_busy_end", 16'(sBusy), 16'd0);
    end
    checkVal("small_level", 16'(sFifoLevel), 16'd0);
    checkVal("small_wr_ready", 16'(sWrReady), 16'd1);
    checkVal("small_overrun", 16'(sOverrun), 16'd0);
    checkVal("small_rep", 16'(sRepFlag), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
